decoder_n_seq: RTL and testbench

//  Parametrised, registered binary-to-one-hot decoder with valid/ready handshakes on input and output.

---
 rtl/decoder_pkg.sv | 16 +
 rtl/onehot_dec.sv | 23 ++
 rtl/decoder_n_seq.sv | 116 +++++++++++
 tb/tb_decoder_n_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
// FSM encoding plus an index-width helper that never collapses to zero bits.
package decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // $clog2(1) is 0, which would leave the sweep index without a bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decode; codes at or above OUT_N flag err with an all-zero vector.
// Zero latency, no flow control of its own.
module onehot_dec #(
  parameter int IN_W  = 2,
  parameter int OUT_N = 4
) (
  input  logic [IN_W-1:0]  code,
  output logic [OUT_N-1:0] onehot,
  output logic             err
);

  // One extra bit so OUT_N == 2**IN_W still fits in the comparison constant.
  localparam logic [IN_W:0] LIMIT = (IN_W + 1)'(OUT_N);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < OUT_N; k++) begin
      onehot[k] = (code == IN_W'(k));
    end
    err = ({1'b0, code} >= LIMIT);
  end

endmodule

// File: rtl/decoder_n_seq.sv
// Registered one-hot decoder with a walking-one scan sweep; 1-cycle latency from accept to out_valid.
// Output register holds under out_ready=0; in_ready and sweep advance both wait for a free output slot.
module decoder_n_seq
  import decoder_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sel,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_N-1:0] out_onehot,
  output logic             out_err
);

  localparam int               IDX_W    = idx_width(OUT_N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_N - 1);
  localparam logic [OUT_N-1:0] ONE      = OUT_N'(1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             slot_free;
  logic             in_acc;
  logic             scan_load;
  logic             last_hs;
  logic [OUT_N-1:0] dec_onehot;
  logic             dec_err;

  onehot_dec #(
    .IN_W  (IN_W),
    .OUT_N (OUT_N)
  ) u_dec (
    .code   (in_sel),
    .onehot (dec_onehot),
    .err    (dec_err)
  );

  assign slot_free = !out_valid || out_ready;
  assign in_acc    = in_valid && in_ready;
  assign scan_load = (state == S_SCAN) && slot_free;
  assign last_hs   = (state == S_DRAIN) && out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (scan_start) state_nxt = S_SCAN;
      S_SCAN:  if (scan_load && (idx == IDX_LAST)) state_nxt = S_DRAIN;
      S_DRAIN: if (last_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // scan_start wins over a same-cycle in_valid by closing in_ready.
  always_comb begin
    in_ready  = 1'b0;
    scan_busy = 1'b0;
    case (state)
      S_IDLE:          in_ready  = !scan_start && slot_free;
      S_SCAN, S_DRAIN: scan_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if ((state == S_IDLE) && scan_start) begin
      idx <= '0;
    end else if (scan_load && (idx != IDX_LAST)) begin
      idx <= idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_err    <= 1'b0;
    end else if (in_acc) begin
      out_valid  <= 1'b1;
      out_onehot <= dec_onehot;
      out_err    <= dec_err;
    end else if (scan_load) begin
      out_valid  <= 1'b1;
      out_onehot <= ONE << idx;
      out_err    <= 1'b0;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_done <= 1'b0;
    end else begin
      scan_done <= last_hs;
    end
  end

endmodule

// File: tb/tb_decoder_n_seq.sv
// Directed bench: table of decode/backpressure vectors on a 2->4 instance, a 3->5 instance for
// error codes, and hand-written sequences for scan sweep, start collisions and mid-sweep reset.
module tb_decoder_n_seq;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_in_valid, a_in_ready, a_scan_start, a_scan_busy, a_scan_done;
  logic       a_out_valid, a_out_ready, a_out_err;
  logic [1:0] a_in_sel;
  logic [3:0] a_out_onehot;

  logic       b_in_valid, b_in_ready, b_scan_start, b_scan_busy, b_scan_done;
  logic       b_out_valid, b_out_ready, b_out_err;
  logic [2:0] b_in_sel;
  logic [4:0] b_out_onehot;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder_n_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_sel     (a_in_sel),
    .scan_start (a_scan_start),
    .scan_busy  (a_scan_busy),
    .scan_done  (a_scan_done),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_onehot (a_out_onehot),
    .out_err    (a_out_err)
  );

  decoder_n_seq #(.IN_W(3), .OUT_N(5)) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_sel     (b_in_sel),
    .scan_start (b_scan_start),
    .scan_busy  (b_scan_busy),
    .scan_done  (b_scan_done),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_onehot (b_out_onehot),
    .out_err    (b_out_err)
  );

  typedef struct {
    logic       vld;
    logic [1:0] sel;
    logic       rdy;
    logic       x_in_ready;
    logic       x_vld;
    logic [3:0] x_oh;
    logic       x_err;
    logic       chk_dat;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int beats;
    int bad;
    int dones;
    int seen;
    logic [3:0] exp_oh;

    //                vld sel   rdy  inr  vld  onehot   err  chk
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_sel = '0; a_scan_start = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_sel = '0; b_scan_start = 1'b0; b_out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_onehot", 32'(a_out_onehot), 32'd0);
    check("rst_out_err", 32'(a_out_err), 32'd0);
    check("rst_scan_busy", 32'(a_scan_busy), 32'd0);
    check("rst_scan_done", 32'(a_scan_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode, full throughput, backpressure hold and release
    for (int i = 0; i < 12; i++) begin
      a_in_valid  = tbl[i].vld;
      a_in_sel    = tbl[i].sel;
      a_out_ready = tbl[i].rdy;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(a_in_ready), 32'(tbl[i].x_in_ready));
      tick();
      check($sformatf("v%0d_out_valid", i), 32'(a_out_valid), 32'(tbl[i].x_vld));
      if (tbl[i].chk_dat) begin
        check($sformatf("v%0d_out_onehot", i), 32'(a_out_onehot), 32'(tbl[i].x_oh));
        check($sformatf("v%0d_out_err", i), 32'(a_out_err), 32'(tbl[i].x_err));
      end
    end
    a_in_valid = 1'b0;

    // Out-of-range codes on the 3->5 instance, including the OUT_N boundary
    b_in_valid = 1'b1; b_in_sel = 3'd6;
    tick();
    check("e6_out_valid", 32'(b_out_valid), 32'd1);
    check("e6_out_onehot", 32'(b_out_onehot), 32'd0);
    check("e6_out_err", 32'(b_out_err), 32'd1);
    b_in_sel = 3'd4;
    tick();
    check("e4_out_onehot", 32'(b_out_onehot), 32'b10000);
    check("e4_out_err", 32'(b_out_err), 32'd0);
    b_in_sel = 3'd5;
    tick();
    check("e5_out_onehot", 32'(b_out_onehot), 32'd0);
    check("e5_out_err", 32'(b_out_err), 32'd1);
    b_in_valid = 1'b0;
    tick();
    check("e_idle_out_valid", 32'(b_out_valid), 32'd0);

    // Plain sweep
    a_out_ready = 1'b1;
    a_scan_start = 1'b1;
    #1;
    check("s_in_ready_on_start", 32'(a_in_ready), 32'd0);
    tick();
    a_scan_start = 1'b0;
    check("s_busy_entry", 32'(a_scan_busy), 32'd1);
    check("s_valid_entry", 32'(a_out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_oh = 4'b0001 << k;
      check($sformatf("s_beat%0d_valid", k), 32'(a_out_valid), 32'd1);
      check($sformatf("s_beat%0d_onehot", k), 32'(a_out_onehot), 32'(exp_oh));
      check($sformatf("s_beat%0d_err", k), 32'(a_out_err), 32'd0);
      check($sformatf("s_beat%0d_busy", k), 32'(a_scan_busy), 32'd1);
      check($sformatf("s_beat%0d_in_ready", k), 32'(a_in_ready), 32'd0);
      check($sformatf("s_beat%0d_done", k), 32'(a_scan_done), 32'd0);
    end
    tick();
    check("s_done_pulse", 32'(a_scan_done), 32'd1);
    check("s_busy_after", 32'(a_scan_busy), 32'd0);
    check("s_valid_after", 32'(a_out_valid), 32'd0);
    tick();
    check("s_done_cleared", 32'(a_scan_done), 32'd0);

    // scan_start colliding with in_valid, then re-pulsed mid-sweep
    a_scan_start = 1'b1; a_in_valid = 1'b1; a_in_sel = 2'd2;
    #1;
    check("c_in_ready_collide", 32'(a_in_ready), 32'd0);
    beats = 0; bad = 0; dones = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (a_out_valid) begin
        if (beats >= 4 || a_out_onehot !== (4'b0001 << beats) || a_out_err !== 1'b0) bad++;
        beats++;
      end
      if (a_scan_done) dones++;
      a_scan_start = (c == 2);
      a_in_valid   = (c < 2);
      if (c == 0) begin
        #1;
        check("c_in_ready_busy", 32'(a_in_ready), 32'd0);
      end
    end
    check("c_beat_count", 32'(beats), 32'd4);
    check("c_beat_errors", 32'(bad), 32'd0);
    check("c_done_count", 32'(dones), 32'd1);

    // Asynchronous reset mid-sweep with a beat pending
    a_scan_start = 1'b1;
    tick();
    a_scan_start = 1'b0;
    tick();
    a_out_ready = 1'b0;
    check("r_pre_valid", 32'(a_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r_out_valid", 32'(a_out_valid), 32'd0);
    check("r_out_onehot", 32'(a_out_onehot), 32'd0);
    check("r_out_err", 32'(a_out_err), 32'd0);
    check("r_scan_busy", 32'(a_scan_busy), 32'd0);
    check("r_scan_done", 32'(a_scan_done), 32'd0);
    tick();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (a_scan_done || a_out_valid || a_scan_busy) seen++;
    end
    check("r_quiet_after", 32'(seen), 32'd0);
    a_in_valid = 1'b1; a_in_sel = 2'd1;
    tick();
    a_in_valid = 1'b0;
    check("r_decode_valid", 32'(a_out_valid), 32'd1);
    check("r_decode_onehot", 32'(a_out_onehot), 32'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
